// File: rtl/deadlock_monitor_pkg.sv
// Shared types and width helpers for the kernel deadlock monitors.
// Imported by the monitor top and its snapshot summary sub-module.
package deadlock_monitor_pkg;

    typedef enum logic [1:0] {
        ST_STARTUP = 2'd0,
        ST_MONITOR = 2'd1,
        ST_CONFIRM = 2'd2,
        ST_LOCKED  = 2'd3
    } mon_state_t;

    // Bits needed to hold 0..n; never narrower than one bit.
    function automatic int bits_for(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    // Bits needed to index 0..n-1; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/deadlock_kernel_monitor_param_summary.sv
// Combinational diagnosis of a stall snapshot: popcount,
// lowest set index and a non-zero flag.
module deadlock_axis_summary
    import deadlock_monitor_pkg::*;
#(
    parameter int NUM_AXIS = 2
) (
    input  logic [NUM_AXIS-1:0]           i_snapshot,
    output logic [bits_for(NUM_AXIS)-1:0] o_count,
    output logic [idx_w(NUM_AXIS)-1:0]    o_first_idx,
    output logic                          o_first_valid
);

    localparam int CNW = bits_for(NUM_AXIS);
    localparam int IW  = idx_w(NUM_AXIS);

    logic [CNW-1:0] w_count;
    logic [IW-1:0]  w_idx;

    // Scan high to low so the last hit is the lowest set bit.
    always_comb begin
        w_count = '0;
        w_idx   = '0;
        for (int i = NUM_AXIS - 1; i >= 0; i--) begin
            if (i_snapshot[i]) begin
                w_count = w_count + CNW'(1);
                w_idx   = IW'(i);
            end
        end
    end

    assign o_count       = w_count;
    assign o_first_idx   = w_idx;
    assign o_first_valid = |i_snapshot;

endmodule

// File: rtl/deadlock_kernel_monitor_param.sv
// Kernel-level deadlock monitor: confirms a sustained stall over N
// AXIS ports and M instances, then latches a diagnosable snapshot.
module deadlock_kernel_monitor_param
    import deadlock_monitor_pkg::*;
#(
    parameter int NUM_AXIS       = 2,
    parameter int NUM_INST       = 3,
    parameter int STARTUP_CYCLES = 10,
    parameter int CONFIRM_CYCLES = 2
) (
    input  logic                          kernel_monitor_clock,
    input  logic                          kernel_monitor_reset,
    input  logic [NUM_AXIS-1:0]           axis_block_sigs,
    input  logic [NUM_INST-1:0]           inst_idle_sigs,
    input  logic [NUM_INST-1:0]           inst_block_sigs,
    input  logic                          enable,
    input  logic                          rearm,
    output logic                          kernel_block,
    output logic                          deadlock,
    output logic                          deadlock_pulse,
    output logic [NUM_AXIS-1:0]           axis_snapshot,
    output logic [bits_for(NUM_AXIS)-1:0] blocked_count,
    output logic [idx_w(NUM_AXIS)-1:0]    first_blocked_idx,
    output logic                          first_blocked_valid
);

    localparam int SW = bits_for(STARTUP_CYCLES);
    localparam int CW = bits_for(CONFIRM_CYCLES);
    localparam logic [SW-1:0] S_LAST =
        SW'((STARTUP_CYCLES > 0) ? STARTUP_CYCLES - 1 : 0);
    localparam logic [CW-1:0] C_LAST = CW'(CONFIRM_CYCLES);
    localparam mon_state_t RST_STATE =
        (STARTUP_CYCLES == 0) ? ST_MONITOR : ST_STARTUP;

    mon_state_t          r_state;
    logic [SW-1:0]       r_scnt;
    logic [CW-1:0]       r_ccnt;
    logic                r_kernel_block;
    logic                r_deadlock;
    logic                r_pulse;
    logic [NUM_AXIS-1:0] r_snap;

    logic                w_raw;
    logic [CW-1:0]       w_cnext;

    // All instances idle-or-blocked, not all idle, and something blocks.
    assign w_raw = (&(inst_idle_sigs | inst_block_sigs))
                 & ~(&inst_idle_sigs)
                 & ((|axis_block_sigs) | (|inst_block_sigs));

    assign w_cnext = r_ccnt + CW'(1);

    always_ff @(posedge kernel_monitor_clock) begin
        if (kernel_monitor_reset) begin
            r_state        <= RST_STATE;
            r_scnt         <= '0;
            r_ccnt         <= '0;
            r_kernel_block <= 1'b0;
            r_deadlock     <= 1'b0;
            r_pulse        <= 1'b0;
            r_snap         <= '0;
        end else begin
            r_kernel_block <= w_raw;
            r_pulse        <= 1'b0;
            case (r_state)
                ST_STARTUP: begin
                    if (r_scnt == S_LAST) begin
                        r_state <= ST_MONITOR;
                        r_scnt  <= '0;
                    end else begin
                        r_scnt <= r_scnt + SW'(1);
                    end
                end
                ST_MONITOR: begin
                    r_ccnt <= '0;
                    if (enable && w_raw) begin
                        r_ccnt <= CW'(1);
                        if (CONFIRM_CYCLES == 1) begin
                            r_state    <= ST_LOCKED;
                            r_snap     <= axis_block_sigs;
                            r_deadlock <= 1'b1;
                            r_pulse    <= 1'b1;
                        end else begin
                            r_state <= ST_CONFIRM;
                        end
                    end
                end
                ST_CONFIRM: begin
                    if (!enable || !w_raw) begin
                        r_state <= ST_MONITOR;
                        r_ccnt  <= '0;
                    end else begin
                        r_ccnt <= w_cnext;
                        if (w_cnext == C_LAST) begin
                            r_state    <= ST_LOCKED;
                            r_snap     <= axis_block_sigs;
                            r_deadlock <= 1'b1;
                            r_pulse    <= 1'b1;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (rearm) begin
                        r_state    <= ST_MONITOR;
                        r_scnt     <= '0;
                        r_ccnt     <= '0;
                        r_deadlock <= 1'b0;
                        r_snap     <= '0;
                    end
                end
                default: r_state <= RST_STATE;
            endcase
        end
    end

    assign kernel_block   = r_kernel_block;
    assign deadlock       = r_deadlock;
    assign deadlock_pulse = r_pulse;
    assign axis_snapshot  = r_snap;

    deadlock_axis_summary #(
        .NUM_AXIS(NUM_AXIS)
    ) u_summary (
        .i_snapshot    (r_snap),
        .o_count       (blocked_count),
        .o_first_idx   (first_blocked_idx),
        .o_first_valid (first_blocked_valid)
    );

endmodule

// File: tb/tb_deadlock_kernel_monitor_param.sv
// Directed bench for the kernel deadlock monitor: a default instance
// (A) and a 4-port, 3-cycle-confirm, 4-cycle-startup instance (B).
module tb_deadlock_kernel_monitor_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic       a_rst, a_en, a_rearm;
    logic [1:0] a_axis;
    logic [2:0] a_idle, a_blk;
    logic       a_kb, a_dl, a_pl;
    logic [1:0] a_snap;
    logic [1:0] a_cnt;
    logic       a_idx;
    logic       a_val;

    logic       b_rst, b_en, b_rearm;
    logic [3:0] b_axis;
    logic [2:0] b_idle, b_blk;
    logic       b_kb, b_dl, b_pl;
    logic [3:0] b_snap;
    logic [2:0] b_cnt;
    logic [1:0] b_idx;
    logic       b_val;

    deadlock_kernel_monitor_param u_a (
        .kernel_monitor_clock (clk),
        .kernel_monitor_reset (a_rst),
        .axis_block_sigs      (a_axis),
        .inst_idle_sigs       (a_idle),
        .inst_block_sigs      (a_blk),
        .enable               (a_en),
        .rearm                (a_rearm),
        .kernel_block         (a_kb),
        .deadlock             (a_dl),
        .deadlock_pulse       (a_pl),
        .axis_snapshot        (a_snap),
        .blocked_count        (a_cnt),
        .first_blocked_idx    (a_idx),
        .first_blocked_valid  (a_val)
    );

    deadlock_kernel_monitor_param #(
        .NUM_AXIS       (4),
        .NUM_INST       (3),
        .STARTUP_CYCLES (4),
        .CONFIRM_CYCLES (3)
    ) u_b (
        .kernel_monitor_clock (clk),
        .kernel_monitor_reset (b_rst),
        .axis_block_sigs      (b_axis),
        .inst_idle_sigs       (b_idle),
        .inst_block_sigs      (b_blk),
        .enable               (b_en),
        .rearm                (b_rearm),
        .kernel_block         (b_kb),
        .deadlock             (b_dl),
        .deadlock_pulse       (b_pl),
        .axis_snapshot        (b_snap),
        .blocked_count        (b_cnt),
        .first_blocked_idx    (b_idx),
        .first_blocked_valid  (b_val)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic b_raw(input logic raw, input logic [3:0] axis);
        b_axis = axis;
        b_idle = raw ? 3'b001 : 3'b111;
        b_blk  = raw ? 3'b110 : 3'b000;
    endtask

    task automatic test_reset();
        a_rst = 1'b1; a_en = 1'b1; a_rearm = 1'b0;
        a_axis = 2'b01; a_idle = 3'b001; a_blk = 3'b110;
        b_rst = 1'b1; b_en = 1'b1; b_rearm = 1'b0;
        b_raw(1'b1, 4'b1111);
        repeat (3) tick();
        n_vec++;
        if ({a_kb, a_dl, a_pl, a_snap, a_cnt, a_idx, a_val} !== 10'b0) begin
            n_err++;
            $display("FAIL reset_a: got %b expected 0",
                     {a_kb, a_dl, a_pl, a_snap, a_cnt, a_idx, a_val});
        end
        n_vec++;
        if ({b_kb, b_dl, b_pl, b_snap, b_cnt, b_idx, b_val} !== 13'b0) begin
            n_err++;
            $display("FAIL reset_b: got %b expected 0",
                     {b_kb, b_dl, b_pl, b_snap, b_cnt, b_idx, b_val});
        end
    endtask

    task automatic test_startup_latency();
        a_rst = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            tick();
            n_vec++;
            if (a_dl !== (k >= 12) || a_pl !== (k == 12)) begin
                n_err++;
                $display("FAIL latency_e%0d: got dl=%b pl=%b expected dl=%b pl=%b",
                         k, a_dl, a_pl, k >= 12, k == 12);
            end
            if (k == 1) begin
                n_vec++;
                if (a_kb !== 1'b1) begin
                    n_err++;
                    $display("FAIL kernel_block_lag: got %b expected 1", a_kb);
                end
            end
        end
        n_vec++;
        if ({a_snap, a_cnt, a_idx, a_val} !== {2'b01, 2'd1, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL snapshot_a: got %b expected 01_01_0_1",
                     {a_snap, a_cnt, a_idx, a_val});
        end
    endtask

    task automatic test_snapshot();
        b_rst = 1'b1;
        b_raw(1'b1, 4'b0110);
        repeat (2) tick();
        b_rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            n_vec++;
            if (b_dl !== (k >= 7) || b_pl !== (k == 7)) begin
                n_err++;
                $display("FAIL snap_lock_e%0d: got dl=%b pl=%b expected dl=%b pl=%b",
                         k, b_dl, b_pl, k >= 7, k == 7);
            end
        end
        n_vec++;
        if ({b_snap, b_cnt, b_idx, b_val} !== {4'b0110, 3'd2, 2'd1, 1'b1}) begin
            n_err++;
            $display("FAIL snapshot_b: got %b expected 0110_010_01_1",
                     {b_snap, b_cnt, b_idx, b_val});
        end
    endtask

    task automatic test_pattern();
        logic pat [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        b_rst = 1'b1;
        b_raw(1'b0, 4'b0000);
        repeat (2) tick();
        b_rst = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 6; i++) begin
            b_raw(pat[i], 4'b0011);
            tick();
            n_vec++;
            if (b_dl !== (i == 5) || b_pl !== (i == 5)) begin
                n_err++;
                $display("FAIL pattern_s%0d: got dl=%b pl=%b expected %b",
                         i + 1, b_dl, b_pl, i == 5);
            end
        end
    endtask

    task automatic test_all_idle();
        a_rst = 1'b1;
        a_axis = 2'b11; a_idle = 3'b111; a_blk = 3'b000;
        repeat (2) tick();
        a_rst = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            n_vec++;
            if (a_dl !== 1'b0 || a_kb !== 1'b0) begin
                n_err++;
                $display("FAIL all_idle_e%0d: got dl=%b kb=%b expected 0 0",
                         k, a_dl, a_kb);
            end
        end
    endtask

    task automatic test_hold_rearm();
        b_rst = 1'b1;
        b_raw(1'b1, 4'b1000);
        repeat (2) tick();
        b_rst = 1'b0;
        repeat (7) tick();
        for (int k = 0; k < 20; k++) begin
            b_axis = 4'($urandom);
            b_idle = 3'($urandom);
            b_blk  = 3'($urandom);
            b_en   = 1'($urandom);
            tick();
            n_vec++;
            if ({b_dl, b_pl, b_snap, b_cnt, b_idx, b_val}
                    !== {1'b1, 1'b0, 4'b1000, 3'd1, 2'd3, 1'b1}) begin
                n_err++;
                $display("FAIL locked_hold_%0d: got %b expected 1_0_1000_001_11_1",
                         k, {b_dl, b_pl, b_snap, b_cnt, b_idx, b_val});
            end
        end
        b_en = 1'b1;
        b_raw(1'b1, 4'b0001);
        b_rearm = 1'b1;
        tick();
        b_rearm = 1'b0;
        n_vec++;
        if ({b_dl, b_snap, b_val} !== 6'b0) begin
            n_err++;
            $display("FAIL rearm_clear: got %b expected 0",
                     {b_dl, b_snap, b_val});
        end
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_vec++;
            if (b_dl !== (k == 3)) begin
                n_err++;
                $display("FAIL relock_e%0d: got %b expected %b", k, b_dl, k == 3);
            end
        end
        n_vec++;
        if ({b_snap, b_cnt, b_idx, b_val} !== {4'b0001, 3'd1, 2'd0, 1'b1}) begin
            n_err++;
            $display("FAIL relock_snap: got %b expected 0001_001_00_1",
                     {b_snap, b_cnt, b_idx, b_val});
        end
    endtask

    task automatic test_reset_vs_lock();
        b_rst = 1'b1;
        b_raw(1'b1, 4'b0101);
        repeat (2) tick();
        b_rst = 1'b0;
        repeat (6) tick();
        b_rst = 1'b1;
        tick();
        n_vec++;
        if (b_dl !== 1'b0 || b_pl !== 1'b0) begin
            n_err++;
            $display("FAIL reset_wins: got dl=%b pl=%b expected 0 0", b_dl, b_pl);
        end
        b_rst = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            n_vec++;
            if (b_dl !== (k == 7)) begin
                n_err++;
                $display("FAIL restartup_e%0d: got %b expected %b", k, b_dl, k == 7);
            end
        end
    endtask

    task automatic test_enable();
        a_rst = 1'b1;
        a_en = 1'b0;
        a_axis = 2'b10; a_idle = 3'b001; a_blk = 3'b110;
        repeat (2) tick();
        a_rst = 1'b0;
        a_rearm = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            n_vec++;
            if (a_dl !== 1'b0) begin
                n_err++;
                $display("FAIL enable_off_e%0d: got %b expected 0", k, a_dl);
            end
        end
        a_rearm = 1'b0;
        a_en = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            tick();
            n_vec++;
            if (a_dl !== (k == 2)) begin
                n_err++;
                $display("FAIL enable_on_e%0d: got %b expected %b", k, a_dl, k == 2);
            end
        end
        n_vec++;
        if ({a_snap, a_cnt, a_idx, a_val} !== {2'b10, 2'd1, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL enable_snap: got %b expected 10_01_1_1",
                     {a_snap, a_cnt, a_idx, a_val});
        end
    endtask

    initial begin
        test_reset();
        test_startup_latency();
        test_snapshot();
        test_pattern();
        test_all_idle();
        test_hold_rearm();
        test_reset_vs_lock();
        test_enable();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
